// File: rtl/pe_port_arbiter_pkg.sv
// pe_port_arbiter_pkg
// Shared types and helpers for the PE output-port arbiter.
//   arbState_t  : arbiter FSM states (IDLE, GRANT)
//   BURST_CNT_W : width of the per-grant burst counter
//   MAX_REQ     : largest requester count the round-robin helper handles
//   rrNextValid : first valid requester at or above a start pointer, with wrap

package pe_port_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbState_t;

  localparam int BURST_CNT_W = 4;
  localparam int MAX_REQ     = 16;

  // Walks the requesters starting at startPtr and wrapping at numReq, and
  // returns the first index whose valid bit is set. When nothing is valid the
  // start pointer is returned, and callers only use the result when at least
  // one requester is valid.
  function automatic logic [3:0] rrNextValid(
    input logic [MAX_REQ-1:0] valid,
    input logic [3:0]         startPtr,
    input int                 numReq
  );
    logic [3:0] result;
    logic       found;
    int         idx;
    result = startPtr;
    found  = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(startPtr) + k) % numReq;
      if ((k < numReq) && !found && valid[idx]) begin
        result = 4'(idx);
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pe_port_arbiter_fifo2.sv
// FIFO2
// Two-entry FIFO with registered head output.
//   CLK     : clock
//   RST     : synchronous reset, active low
//   D_IN    : data to enqueue
//   ENQ     : enqueue request
//   FULL_N  : high when at least one entry is free
//   D_OUT   : head entry
//   DEQ     : dequeue request, ignored while empty
//   EMPTY_N : high when the head is valid
//   CLR     : synchronous clear, active high

module FIFO2 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             ENQ,
  output logic             FULL_N,
  output logic [WIDTH-1:0] D_OUT,
  input  logic             DEQ,
  output logic             EMPTY_N,
  input  logic             CLR
);

  logic [WIDTH-1:0] r_data0;
  logic [WIDTH-1:0] r_data1;
  logic [1:0]       r_count;
  logic             w_doDeq;
  logic             w_doEnq;

  // A dequeue only happens when there is something to remove. An enqueue is
  // accepted when a slot is free, or when the FIFO is full but the head is
  // leaving in the same cycle, so a full FIFO can pass data straight through.
  always_comb begin
    w_doDeq = DEQ && (r_count != 2'd0);
    w_doEnq = ENQ && ((r_count != 2'd2) || w_doDeq);
  end

  // r_data0 is always the head. With two entries present, a dequeue shifts
  // r_data1 forward and any simultaneous enqueue lands in the freed slot.
  always_ff @(posedge CLK) begin
    if (!RST || CLR) begin
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_doEnq) begin
            r_data0 <= D_IN;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          case ({w_doEnq, w_doDeq})
            2'b11: r_data0 <= D_IN;
            2'b10: begin
              r_data1 <= D_IN;
              r_count <= 2'd2;
            end
            2'b01: r_count <= 2'd0;
            default: r_count <= r_count;
          endcase
        end
        default: begin
          case ({w_doEnq, w_doDeq})
            2'b11: begin
              r_data0 <= r_data1;
              r_data1 <= D_IN;
            end
            2'b01: begin
              r_data0 <= r_data1;
              r_count <= 2'd1;
            end
            default: r_count <= r_count;
          endcase
        end
      endcase
    end
  end

  assign D_OUT   = r_data0;
  assign EMPTY_N = (r_count != 2'd0);
  assign FULL_N  = (r_count != 2'd2);

endmodule

// File: rtl/pe_port_arbiter.sv
// pe_port_arbiter
// Round-robin arbiter sharing one router injection port among NUM_REQ PE
// output ports. A grant lasts up to MAX_BURST flits; granted flits are
// buffered in a two-entry FIFO in front of the router.
//   CLK               : clock
//   RST               : synchronous reset, active high
//   req_dataIn        : requester flits, requester i at [i*WIDTH +: WIDTH]
//   req_dataValid     : requester i has a flit
//   req_dataDeq       : one-hot or zero, flit of requester i consumed
//   outport_dataOut   : head of the output FIFO
//   outport_dataValid : output FIFO not empty
//   outport_dataDeq   : downstream consumes the head this cycle
//   grant_owner       : index of the current owner
//   busy              : a grant is active

module pe_port_arbiter
  import pe_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ*WIDTH-1:0]   req_dataIn,
  input  logic [NUM_REQ-1:0]         req_dataValid,
  output logic [NUM_REQ-1:0]         req_dataDeq,
  output logic [WIDTH-1:0]           outport_dataOut,
  output logic                       outport_dataValid,
  input  logic                       outport_dataDeq,
  output logic [$clog2(NUM_REQ)-1:0] grant_owner,
  output logic                       busy
);

  localparam int OWNER_W = $clog2(NUM_REQ);

  arbState_t              r_state;
  arbState_t              w_stateNext;
  logic [OWNER_W-1:0]     r_owner;
  logic [OWNER_W-1:0]     w_ownerNext;
  logic [BURST_CNT_W-1:0] r_burstCnt;
  logic [BURST_CNT_W-1:0] w_burstCntNext;
  logic [BURST_CNT_W-1:0] w_burstInc;
  logic [OWNER_W-1:0]     r_rrPtr;
  logic [OWNER_W-1:0]     w_rrPtrNext;
  logic [OWNER_W-1:0]     w_releasePtr;
  logic [OWNER_W-1:0]     w_selIdx;
  logic [MAX_REQ-1:0]     w_validPad;
  logic [NUM_REQ-1:0]     w_deq;
  logic                   w_enq;
  logic [WIDTH-1:0]       w_ownerData;
  logic                   w_ownerValid;
  logic                   w_fifoNotFull;
  logic                   w_fifoNotEmpty;
  logic [WIDTH-1:0]       w_fifoData;

  // Pick out the owner's flit and valid bit with an explicit compare per
  // requester, which stays in range for non-power-of-two NUM_REQ.
  always_comb begin
    w_ownerData  = '0;
    w_ownerValid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == OWNER_W'(i)) begin
        w_ownerData  = req_dataIn[i*WIDTH +: WIDTH];
        w_ownerValid = req_dataValid[i];
      end
    end
  end

  // Round-robin candidate for the next grant, plus the pointer value that a
  // release leaves behind (the requester just after the current owner).
  always_comb begin
    w_validPad                = '0;
    w_validPad[NUM_REQ-1:0]   = req_dataValid;
    w_selIdx                  = OWNER_W'(rrNextValid(w_validPad, 4'(r_rrPtr), NUM_REQ));
    w_releasePtr              = (r_owner == OWNER_W'(NUM_REQ - 1)) ? '0 : r_owner + OWNER_W'(1);
    w_burstInc                = r_burstCnt + BURST_CNT_W'(1);
  end

  // Arbiter next-state logic. IDLE spends one cycle choosing an owner. GRANT
  // moves one flit per cycle while the owner is valid and the FIFO has room,
  // holds everything while the FIFO is full, and gives the port up after
  // MAX_BURST flits or as soon as the owner runs dry. The handshake back to
  // the PEs never looks at outport_dataDeq, so there is no combinational path
  // from the router side to the PE side.
  always_comb begin
    w_stateNext    = r_state;
    w_ownerNext    = r_owner;
    w_burstCntNext = r_burstCnt;
    w_rrPtrNext    = r_rrPtr;
    w_deq          = '0;
    w_enq          = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_dataValid) begin
          w_stateNext    = GRANT;
          w_ownerNext    = w_selIdx;
          w_burstCntNext = '0;
        end
      end
      GRANT: begin
        if (!w_ownerValid) begin
          w_stateNext = IDLE;
          w_rrPtrNext = w_releasePtr;
        end else if (w_fifoNotFull) begin
          w_deq          = NUM_REQ'(1) << r_owner;
          w_enq          = 1'b1;
          w_burstCntNext = w_burstInc;
          if (w_burstInc == BURST_CNT_W'(MAX_BURST)) begin
            w_stateNext = IDLE;
            w_rrPtrNext = w_releasePtr;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State registers. Reset abandons any partial burst and restarts the
  // round-robin search at requester 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_burstCnt <= '0;
      r_rrPtr    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_owner    <= w_ownerNext;
      r_burstCnt <= w_burstCntNext;
      r_rrPtr    <= w_rrPtrNext;
    end
  end

  // The output FIFO is cleared by the same reset, so nothing accepted before
  // reset is forwarded afterwards.
  FIFO2 #(
    .WIDTH (WIDTH)
  ) u_outFifo (
    .CLK     (CLK),
    .RST     (~RST),
    .D_IN    (w_ownerData),
    .ENQ     (w_enq),
    .FULL_N  (w_fifoNotFull),
    .D_OUT   (w_fifoData),
    .DEQ     (outport_dataDeq && w_fifoNotEmpty),
    .EMPTY_N (w_fifoNotEmpty),
    .CLR     (1'b0)
  );

  // Outputs are forced quiet while reset is held so a PE never loses a flit
  // into a FIFO that is about to be wiped.
  assign req_dataDeq       = RST ? '0 : w_deq;
  assign outport_dataOut   = w_fifoData;
  assign outport_dataValid = w_fifoNotEmpty && !RST;
  assign grant_owner       = RST ? '0 : r_owner;
  assign busy              = (r_state == GRANT) && !RST;

endmodule

// File: tb/tb_pe_port_arbiter.sv
// tb_pe_port_arbiter
// Self-checking bench for pe_port_arbiter. Each PE is a list of pending flits.
// A predictor applies the arbitration rules every cycle, predicts which PE
// gets dequeued and pushes that flit into a scoreboard; a separate monitor
// pops the scoreboard whenever the router side takes a flit.

module tb_pe_port_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 4;
  localparam int OWNER_W   = 2;
  localparam int PE_DEPTH  = 1024;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ*WIDTH-1:0] reqDataIn;
  logic [NUM_REQ-1:0]       reqDataValid;
  logic [NUM_REQ-1:0]       reqDataDeq;
  logic [WIDTH-1:0]         outDataOut;
  logic                     outDataValid;
  logic                     outDataDeq;
  logic [OWNER_W-1:0]       grantOwner;
  logic                     busy;

  logic [WIDTH-1:0] peMem [NUM_REQ][PE_DEPTH];
  int               peHead [NUM_REQ];
  int               peTail [NUM_REQ];
  logic             peGate [NUM_REQ];

  logic [WIDTH-1:0] expQ [$];

  int mBusy;
  int mOwner;
  int mSent;
  int mNext;
  int mFifo;

  int checkCount = 0;
  int failCount  = 0;
  int bpDeqCount = 0;
  logic bpWindow = 1'b0;

  pe_port_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .CLK               (clk),
    .RST               (rst),
    .req_dataIn        (reqDataIn),
    .req_dataValid     (reqDataValid),
    .req_dataDeq       (reqDataDeq),
    .outport_dataOut   (outDataOut),
    .outport_dataValid (outDataValid),
    .outport_dataDeq   (outDataDeq),
    .grant_owner       (grantOwner),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit peHasFlit(input int pe);
    return peHead[pe] != peTail[pe];
  endfunction

  task automatic addFlit(input int pe, input logic [WIDTH-1:0] data);
    if (peTail[pe] < PE_DEPTH) begin
      peMem[pe][peTail[pe]] = data;
      peTail[pe]++;
    end
  endtask

  task automatic setGates(input logic [NUM_REQ-1:0] g);
    for (int i = 0; i < NUM_REQ; i++) peGate[i] = g[i];
  endtask

  // Present each PE's head flit; valid needs both a pending flit and the gate.
  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      reqDataValid[i] = peHasFlit(i) && peGate[i];
      reqDataIn[i*WIDTH +: WIDTH] = peHasFlit(i) ? peMem[i][peHead[i]] : '0;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      nextCycle();
      applyStimulus();
    end
  endtask

  function automatic bit allIdle();
    bit idle;
    idle = (expQ.size() == 0) && !busy && !outDataValid;
    for (int i = 0; i < NUM_REQ; i++) if (peHasFlit(i)) idle = 0;
    return idle;
  endfunction

  // Let every PE empty out with the router side always ready.
  task automatic drain();
    int n;
    n = 0;
    nextCycle();
    rst = 1'b0;
    outDataDeq = 1'b1;
    setGates('1);
    applyStimulus();
    while (!allIdle() && n < 2000) begin
      nextCycle();
      applyStimulus();
      n++;
    end
    checkOutput("drainTimeout", 32'(n >= 2000), 32'd0);
  endtask

  // Predictor: a grant lasts until MAX_BURST flits went out or the owner goes
  // quiet, the output buffer holds two flits, and a new owner is the first
  // valid requester after the last released one. Runs at mid-cycle when the
  // inputs for this cycle are stable.
  logic [NUM_REQ-1:0] predDeq;
  int                 predEnq;
  int                 predOut;
  bit                 predFound;
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rstDeq", 32'(reqDataDeq), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstOutValid", 32'(outDataValid), 32'd0);
      checkOutput("rstOwner", 32'(grantOwner), 32'd0);
      mBusy  = 0;
      mOwner = 0;
      mSent  = 0;
      mNext  = 0;
      mFifo  = 0;
      expQ.delete();
    end else begin
      checkOutput("outValid", 32'(outDataValid), 32'(mFifo > 0));
      checkOutput("busy", 32'(busy), 32'(mBusy));
      checkOutput("owner", 32'(grantOwner), 32'(mOwner));
      predDeq = '0;
      predEnq = 0;
      predOut = (outDataDeq && mFifo > 0) ? 1 : 0;
      if (mBusy == 0) begin
        predFound = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!predFound && reqDataValid[(mNext + k) % NUM_REQ]) begin
            predFound = 1;
            mOwner    = (mNext + k) % NUM_REQ;
            mBusy     = 1;
            mSent     = 0;
          end
        end
      end else if (!reqDataValid[mOwner]) begin
        mBusy = 0;
        mNext = (mOwner + 1) % NUM_REQ;
      end else if (mFifo < 2) begin
        predDeq[mOwner] = 1'b1;
        predEnq = 1;
        expQ.push_back(peMem[mOwner][peHead[mOwner]]);
        peHead[mOwner]++;
        mSent++;
        if (mSent == MAX_BURST) begin
          mBusy = 0;
          mNext = (mOwner + 1) % NUM_REQ;
        end
      end
      checkOutput("reqDeq", 32'(reqDataDeq), 32'(predDeq));
      mFifo = mFifo + predEnq - predOut;
    end
  end

  // Monitor: every flit the router side takes must be the oldest predicted
  // one. Also counts requester 1 handshakes during the backpressure window.
  logic [WIDTH-1:0] monExp;
  always @(negedge clk) begin
    if (!rst && outDataValid && outDataDeq) begin
      if (expQ.size() == 0) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL outUnexpected actual=%0h expected=none at %0t", outDataOut, $time);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("outData", outDataOut, monExp);
      end
    end
    if (bpWindow && reqDataDeq[1]) bpDeqCount++;
  end

  initial begin
    rst        = 1'b1;
    outDataDeq = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      peHead[i] = 0;
      peTail[i] = 0;
      peGate[i] = 1'b0;
    end
    applyStimulus();
    runCycles(3);
    nextCycle();
    rst = 1'b0;
    applyStimulus();
    runCycles(2);

    $display("[TB] single requester burst");
    nextCycle();
    outDataDeq = 1'b1;
    setGates(4'b0100);
    addFlit(2, 32'hA0);
    addFlit(2, 32'hA1);
    addFlit(2, 32'hA2);
    applyStimulus();
    runCycles(10);

    $display("[TB] all requesters continuously valid");
    nextCycle();
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 8; k++) addFlit(i, 32'((i << 24) | k));
    setGates('1);
    applyStimulus();
    runCycles(45);
    drain();

    $display("[TB] backpressure");
    nextCycle();
    outDataDeq = 1'b0;
    setGates(4'b0010);
    for (int k = 0; k < 6; k++) addFlit(1, 32'h1100 + 32'(k));
    bpDeqCount = 0;
    bpWindow   = 1'b1;
    applyStimulus();
    runCycles(10);
    bpWindow = 1'b0;
    checkOutput("bpAccepted", 32'(bpDeqCount), 32'd2);
    outDataDeq = 1'b1;
    runCycles(20);
    drain();

    $display("[TB] round-robin wrap");
    nextCycle();
    setGates(4'b0100);
    addFlit(2, 32'h2200);
    addFlit(2, 32'h2201);
    addFlit(0, 32'h0000);
    addFlit(0, 32'h0001);
    addFlit(1, 32'h1000);
    addFlit(1, 32'h1001);
    applyStimulus();
    nextCycle();
    setGates(4'b0011);
    applyStimulus();
    for (int n = 0; n < 20 && !(busy && grantOwner != 2'd2); n++) begin
      nextCycle();
      applyStimulus();
    end
    checkOutput("wrapOwner", 32'(grantOwner), 32'd0);
    drain();

    $display("[TB] reset mid-burst");
    nextCycle();
    setGates(4'b1000);
    for (int k = 0; k < 6; k++) addFlit(3, 32'h3300 + 32'(k));
    addFlit(0, 32'h0A00);
    addFlit(0, 32'h0A01);
    applyStimulus();
    nextCycle();
    setGates(4'b1001);
    applyStimulus();
    runCycles(1);
    nextCycle();
    rst = 1'b1;
    applyStimulus();
    nextCycle();
    rst = 1'b0;
    applyStimulus();
    checkOutput("postRstBusy", 32'(busy), 32'd0);
    checkOutput("postRstOutValid", 32'(outDataValid), 32'd0);
    checkOutput("postRstDeq", 32'(reqDataDeq), 32'd0);
    for (int n = 0; n < 20 && !busy; n++) begin
      nextCycle();
      applyStimulus();
    end
    checkOutput("postRstOwner", 32'(grantOwner), 32'd0);
    drain();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      nextCycle();
      for (int i = 0; i < NUM_REQ; i++) begin
        if ($urandom_range(0, 3) == 0) addFlit(i, $urandom);
        peGate[i] = ($urandom_range(0, 3) != 0);
      end
      outDataDeq = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 149) == 0);
      applyStimulus();
    end
    drain();
    runCycles(3);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/pe_port_arbiter.md
# pe_port_arbiter

Round-robin arbiter that shares one network output port among NUM_REQ processing-element output ports. Each requester presents a flit with the codebase's valid/deq handshake. The arbiter grants one requester at a time, holding the grant for bursts of up to MAX_BURST flits, and buffers the granted flits in a 2-entry output FIFO. It sits between a cluster of PEs and a single router injection port.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 32, flit width
- MAX_BURST, 4, maximum consecutive flits per grant (1..15)

Ports:
- CLK  in  1  clock
- RST  in  1  reset; one clock, reset is synchronous and active-high
- req_dataIn  in  NUM_REQ*WIDTH  requester flits; requester i occupies bits [i*WIDTH +: WIDTH]
- req_dataValid  in  NUM_REQ  requester i has a flit
- req_dataDeq  out  NUM_REQ  one-hot or zero; flit of requester i consumed this cycle
- outport_dataOut  out  WIDTH  head of output FIFO
- outport_dataValid  out  1  output FIFO not empty
- outport_dataDeq  in  1  downstream consumes head this cycle; ignored when dataValid is 0
- grant_owner  out  $clog2(NUM_REQ)  current owner index
- busy  out  1  state is GRANT

## Operation

- Registers: state (IDLE, GRANT), owner, burst_cnt (4 bits), rr_ptr.
- IDLE:
  - If any req_dataValid is set, select the first valid index searching upward from rr_ptr with wrap-around.
  - Register that index as owner, set burst_cnt=0, go to GRANT.
  - No flit is transferred in the IDLE cycle.
- GRANT, transfer condition: req_dataValid[owner] && fifo notFull.
  - On a transfer: req_dataDeq[owner]=1, enqueue req_dataIn slice, burst_cnt+1.
  - If burst_cnt+1 == MAX_BURST: release.
- GRANT, req_dataValid[owner]==0: release with no transfer.
- GRANT, fifo full with owner valid: stall. Hold owner and burst_cnt; req_dataDeq=0.
- Release: rr_ptr = (owner+1) mod NUM_REQ, state IDLE.
- Non-owner requesters never see req_dataDeq asserted.
- Enqueue and dequeue in the same cycle on a full FIFO are both allowed.
- Reset mid-burst: the partially sent burst is abandoned and FIFO contents are discarded. The PEs retain unsent flits.

## Timing

- Reset values: state IDLE, owner 0, rr_ptr 0, burst_cnt 0, FIFO empty.
- Outputs during and after reset: req_dataDeq all 0, outport_dataValid 0, busy 0, grant_owner 0.
- Request first valid at cycle t while IDLE:
  - grant (busy=1) at t+1
  - first req_dataDeq at t+1 if FIFO not full
  - outport_dataValid at t+2
- Throughput: one flit per cycle within a burst. Each grant costs one arbitration bubble cycle.
- req_dataDeq is combinational from registered state, req_dataValid and FIFO notFull. There is no combinational path from outport_dataDeq to req_dataDeq.
- Release on the last burst transfer and the IDLE selection happen in consecutive cycles. Back-to-back grants therefore alternate transfer and bubble only for MAX_BURST=1.

## Structure

- Shared package holds:
  - state enum {IDLE, GRANT}
  - burst counter width constant (4)
  - helper function for next-valid round-robin search
- Sub-module: the existing FIFO2, width WIDTH.
  - Its reset input is active-low, so drive it with ~RST.
  - CLR is tied to 0.
- Arbiter FSM and round-robin search stay in this module.

## Test plan

- Single requester 2 valid with 3 flits 0xA0..0xA2, outport_dataDeq held 1 → grant_owner=2 at t+1; output shows 0xA0,0xA1,0xA2 on consecutive cycles starting t+2; busy drops after requester 2 deasserts valid.
- All four requesters continuously valid, MAX_BURST=4 → owner sequence 0,1,2,3,0; exactly 4 flits per grant; one bubble between grants.
- Backpressure: outport_dataDeq=0 for 10 cycles with requester 1 streaming → exactly 2 flits are accepted (req_dataDeq pulses twice), owner and burst_cnt are held, no flit is lost or duplicated after release.
- Wrap-around: rr_ptr=3 after owner 2 releases, and only requesters 0 and 1 are valid → requester 0 is granted next.
- Reset asserted mid-burst after 2 of 4 flits → the next cycle has busy=0, outport_dataValid=0, req_dataDeq=0; arbitration after reset starts from requester 0.
